// File: rtl/accum_ctrl.sv
// accum_ctrl: multi-cycle fetch/decode/execute sequencer for the accumulator CPU.
// Owns PC, IR, MAR, MBR, AC; drives a single-port sync RAM and a combinational ALU.
// Ports: clock/reset/start control; mem_* RAM bus; alu_* ALU operands/select/result;
//        in_*/out_* valid-ready I/O for INPUT/OUTPUT; halted/illegal status; pc/ac/ir debug.
module accum_ctrl #(
  parameter int              DATA_WIDTH = 32,
  parameter int              ADDR_WIDTH = 28,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 'h100,
  parameter logic [3:0]      ALU_ADD    = 4'b0010,
  parameter logic [3:0]      ALU_SUB    = 4'b0011
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [DATA_WIDTH-1:0] alu_left,
  output logic [DATA_WIDTH-1:0] alu_right,
  output logic [3:0]            alu_sel,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  halted,
  output logic                  illegal,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] ac,
  output logic [DATA_WIDTH-1:0] ir
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_FETCH_RD, S_FETCH_LAT, S_DECODE,
    S_OP_ADDR, S_OP_RD, S_OP_LAT, S_EXEC,
    S_ST_ADDR, S_ST_WR, S_IO_IN, S_IO_OUT, S_HALT
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d, mbr_q, mbr_d, ac_q, ac_d, out_q, out_d;
  logic                  illegal_q, illegal_d;
  logic                  halt_st;

  logic [3:0]            opcode;
  logic [ADDR_WIDTH-1:0] operand;
  logic [1:0]            skip_sel;
  logic                  skip_take;

  assign opcode   = ir_q[DATA_WIDTH-1 -: 4];
  assign operand  = ir_q[ADDR_WIDTH-1:0];
  assign skip_sel = ir_q[ADDR_WIDTH-1 -: 2];

  always_comb begin
    unique case (skip_sel)
      2'b00:   skip_take = $signed(ac_q) < 0;
      2'b01:   skip_take = (ac_q == '0);
      2'b10:   skip_take = $signed(ac_q) > 0;
      default: skip_take = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mar_d     = mar_q;
    mbr_d     = mbr_q;
    ac_d      = ac_q;
    out_d     = out_q;
    illegal_d = illegal_q;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_oe    = 1'b0;
    alu_sel   = 4'd0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    halt_st   = 1'b0;

    unique case (state_q)
      S_IDLE:      if (start) state_d = S_FETCH;
      S_FETCH:     begin mar_d = pc_q; state_d = S_FETCH_RD; end
      S_FETCH_RD:  begin mem_cs = 1'b1; mem_oe = 1'b1; state_d = S_FETCH_LAT; end
      S_FETCH_LAT: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + ADDR_WIDTH'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (opcode)
          4'h1, 4'h3, 4'h4: begin mar_d = operand; state_d = S_OP_ADDR; end
          4'h2: begin mar_d = operand; mbr_d = ac_q; state_d = S_ST_ADDR; end
          4'h5: state_d = S_IO_IN;
          4'h6: begin out_d = ac_q; state_d = S_IO_OUT; end
          4'h7: state_d = S_HALT;
          4'h8: begin
            if (skip_take) pc_d = pc_q + ADDR_WIDTH'(1);
            state_d = S_FETCH;
          end
          4'h9: begin pc_d = operand; state_d = S_FETCH; end
          4'hA: begin ac_d = '0; state_d = S_FETCH; end
          default: begin illegal_d = 1'b1; state_d = S_HALT; end
        endcase
      end
      S_OP_ADDR: state_d = S_OP_RD;
      S_OP_RD:   begin mem_cs = 1'b1; mem_oe = 1'b1; state_d = S_OP_LAT; end
      S_OP_LAT:  begin mbr_d = mem_rdata; state_d = S_EXEC; end
      S_EXEC: begin
        // Only LOAD/ADD/SUBT reach EXEC, so opcode is one of 1/3/4 here.
        if (opcode == 4'h1) begin
          ac_d = mbr_q;
        end else if (opcode == 4'h3) begin
          alu_sel = ALU_ADD;
          ac_d    = alu_out;
        end else begin
          alu_sel = ALU_SUB;
          ac_d    = alu_out;
        end
        state_d = S_FETCH;
      end
      S_ST_ADDR: state_d = S_ST_WR;
      S_ST_WR:   begin mem_cs = 1'b1; mem_we = 1'b1; state_d = S_FETCH; end
      S_IO_IN: begin
        in_ready = 1'b1;
        if (in_valid) begin ac_d = in_data; state_d = S_FETCH; end
      end
      S_IO_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_FETCH;
      end
      S_HALT:  halt_st = 1'b1;
      default: state_d = S_IDLE;
    endcase

    // Reset overrides strobes combinationally so an in-flight write never lands.
    if (reset) begin
      mem_cs    = 1'b0;
      mem_we    = 1'b0;
      mem_oe    = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      halt_st   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      mar_q     <= '0;
      mbr_q     <= '0;
      ac_q      <= '0;
      out_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mar_q     <= mar_d;
      mbr_q     <= mbr_d;
      ac_q      <= ac_d;
      out_q     <= out_d;
      illegal_q <= illegal_d;
    end
  end

  assign mem_addr  = mar_q;
  assign mem_wdata = mbr_q;
  assign alu_left  = ac_q;
  assign alu_right = mbr_q;
  assign out_data  = out_q;
  assign halted    = halt_st;
  assign illegal   = illegal_q & ~reset;
  assign pc        = pc_q;
  assign ac        = ac_q;
  assign ir        = ir_q;

endmodule

// File: tb/tb_accum_ctrl.sv
module tb_accum_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [27:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_cs, mem_we, mem_oe;
  logic [31:0] alu_left, alu_right, alu_out;
  logic [3:0]  alu_sel;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        halted, illegal;
  logic [27:0] pc;
  logic [31:0] ac, ir;

  int total = 0;
  int bad   = 0;

  // Bench-side RAM: sync read/write plus a preload port used while the DUT is quiet.
  logic [31:0] mem [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  int          wr_cnt = 0;

  always @(posedge clock) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_cs && mem_we) begin
      mem[mem_addr[9:0]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_cs && mem_oe) mem_rdata <= mem[mem_addr[9:0]];
  end

  // Reference ALU.
  always_comb begin
    alu_out = 32'd0;
    if (alu_sel == 4'b0010) alu_out = alu_left + alu_right;
    else if (alu_sel == 4'b0011) alu_out = alu_left - alu_right;
  end

  always #5 clock = ~clock;

  accum_ctrl dut (
    .clock(clock), .reset(reset), .start(start),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
    .alu_left(alu_left), .alu_right(alu_right), .alu_sel(alu_sel), .alu_out(alu_out),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .halted(halted), .illegal(illegal), .pc(pc), .ac(ac), .ir(ir)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!halted && n < 200) begin tick(); n++; end
    chk(tag, {63'd0, halted}, 64'd1);
  endtask

  initial begin
    logic [31:0] snap;
    int n;

    // Reset held with start low: bus must stay quiet every cycle.
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_cs", {63'd0, mem_cs}, 64'd0);
    end
    reset = 1'b0;
    chk("rst_pc", pc, 64'h100);
    chk("rst_ac", ac, 64'h0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk("rst_illegal", {63'd0, illegal}, 64'd0);

    // LOAD/ADD/STORE/HALT program.
    load(10'h100, 32'h1000010A);
    load(10'h101, 32'h3000010B);
    load(10'h102, 32'h2000010C);
    load(10'h103, 32'h70000000);
    load(10'h10A, 32'd5);
    load(10'h10B, 32'd7);
    load(10'h10C, 32'd0);
    chk("idle_cs", {63'd0, mem_cs}, 64'd0);
    go();
    chk("fetch_cs", {63'd0, mem_cs}, 64'd0);
    tick();
    chk("frd_strobe", {61'd0, mem_cs, mem_oe, mem_we}, 64'b110);
    chk("frd_addr", mem_addr, 64'h100);
    repeat (24) tick();
    chk("p1_not_yet_halted", {63'd0, halted}, 64'd0);
    tick();
    chk("p1_halted_at_26", {63'd0, halted}, 64'd1);
    chk("p1_ac", ac, 64'd12);
    chk("p1_pc", pc, 64'h104);
    chk("p1_mem10c", mem[10'h10C], 64'd12);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("halt_sticky", {63'd0, halted}, 64'd1);

    // SKIPCOND AC<0 with AC=-1: skips the first HALT.
    do_reset(2);
    load(10'h10A, 32'hFFFFFFFF);
    load(10'h100, 32'h1000010A);
    load(10'h101, 32'h80000000);
    load(10'h102, 32'h70000000);
    load(10'h103, 32'hA0000000);
    load(10'h104, 32'h70000000);
    go();
    wait_halt("skip_neg_halt");
    chk("skip_neg_ac", ac, 64'h0);
    chk("skip_neg_pc", pc, 64'h105);

    // SKIPCOND AC==0 with AC=-1: no skip.
    do_reset(2);
    load(10'h101, 32'h84000000);
    go();
    wait_halt("skip_zero_halt");
    chk("skip_zero_ac", ac, 64'hFFFFFFFF);
    chk("skip_zero_pc", pc, 64'h103);

    // INPUT / OUTPUT handshakes.
    do_reset(2);
    load(10'h100, 32'h50000000);
    load(10'h101, 32'h60000000);
    load(10'h102, 32'h70000000);
    go();
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk("in_ready_up", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("in_ready_hold", {63'd0, in_ready}, 64'd1);
    end
    in_valid = 1'b1;
    in_data  = 32'h2A;
    tick();
    in_valid = 1'b0;
    in_data  = 32'h0;
    chk("in_ready_drop", {63'd0, in_ready}, 64'd0);
    chk("io_ac", ac, 64'h2A);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    chk("out_valid_up", {63'd0, out_valid}, 64'd1);
    chk("out_data0", out_data, 64'h2A);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("out_valid_hold", {63'd0, out_valid}, 64'd1);
      chk("out_data_stable", out_data, 64'h2A);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_drop", {63'd0, out_valid}, 64'd0);
    wait_halt("io_halt");
    chk("io_pc", pc, 64'h103);

    // Illegal opcode B.
    do_reset(2);
    load(10'h100, 32'hB0000000);
    n = wr_cnt;
    go();
    wait_halt("ill_halt");
    chk("ill_flag", {63'd0, illegal}, 64'd1);
    chk("ill_pc", pc, 64'h101);
    chk("ill_no_write", wr_cnt - n, 64'd0);

    // Reset during ST_WR of a STORE.
    do_reset(2);
    chk("ill_cleared", {63'd0, illegal}, 64'd0);
    load(10'h100, 32'h2000010C);
    load(10'h10C, 32'hDEADBEEF);
    snap = 32'hDEADBEEF;
    go();
    repeat (5) tick();
    chk("stwr_we", {63'd0, mem_we}, 64'd1);
    chk("stwr_addr", mem_addr, 64'h10C);
    reset = 1'b1;
    #1;
    chk("stwr_we_forced", {63'd0, mem_we}, 64'd0);
    chk("stwr_cs_forced", {63'd0, mem_cs}, 64'd0);
    tick();
    reset = 1'b0;
    chk("stwr_pc", pc, 64'h100);
    chk("stwr_ac", ac, 64'h0);
    chk("stwr_word", mem[10'h10C], {32'd0, snap});
    repeat (3) tick();
    chk("stwr_idle_cs", {63'd0, mem_cs}, 64'd0);
    chk("stwr_idle_halted", {63'd0, halted}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accum_ctrl.md
# accum_ctrl

Multi-cycle control unit for the accumulator CPU: owns PC, IR, MAR, MBR and AC, and sequences fetch/decode/execute over the single-port synchronous RAM (`single_port_sync_ram_large`) and the combinational `alu`. It replaces hand-sequenced `@(posedge clock)` steps in benches with one FSM. It also adds a valid/ready I/O port for INPUT/OUTPUT instructions. While idle or halted it leaves the memory bus quiet so a bench can preload RAM.

## Interface
- DATA_WIDTH, 32, word width of RAM, AC, IR, MBR
- ADDR_WIDTH, 28, RAM address width; PC and MAR width; equals IR[27:0]
- RESET_PC, 'h100, PC value after reset
- ALU_ADD, 4'b0010, alu_sel code for ADD
- ALU_SUB, 4'b0011, alu_sel code for SUBT
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  leave IDLE and begin fetching at PC
- mem_addr  out  ADDR_WIDTH  equals MAR
- mem_wdata  out  DATA_WIDTH  equals MBR
- mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after a read strobe
- mem_cs / mem_we / mem_oe  out  1 each  RAM strobes, decoded from state
- alu_left / alu_right  out  DATA_WIDTH  AC / MBR
- alu_sel  out  4  ALU_ADD or ALU_SUB in EXEC, else 0
- alu_out  in  DATA_WIDTH  ALU result
- in_data  in  DATA_WIDTH; in_valid  in  1; in_ready  out  1  INPUT handshake
- out_data  out  DATA_WIDTH; out_valid  out  1; out_ready  in  1  OUTPUT handshake
- halted  out  1; illegal  out  1  status
- pc  out  ADDR_WIDTH; ac  out  DATA_WIDTH; ir  out  DATA_WIDTH  debug views

## Operation
- Reset values: PC=RESET_PC; IR=MAR=MBR=AC=0; out_data=0; state IDLE.
- Strobes while reset is high: mem_cs=mem_we=mem_oe=0, in_ready=0, out_valid=0, halted=0, illegal=0.
- Strobe encoding: read is cs=1, oe=1, we=0. Write is cs=1, we=1, oe=0. All other states drive cs=we=oe=0.
- Opcode is IR[31:28]; operand X is IR[27:0].
- IDLE: wait for start. No other input is examined.
- FETCH: MAR<=PC.
- FETCH_RD: read strobe.
- FETCH_LAT: IR<=mem_rdata; PC<=PC+1, wrapping modulo 2^ADDR_WIDTH.
- DECODE dispatch:
  - 1 LOAD, 3 ADD, 4 SUBT -> OP_ADDR: MAR<=X.
  - 2 STORE -> ST_ADDR: MAR<=X, MBR<=AC.
  - 5 INPUT -> IO_IN.
  - 6 OUTPUT -> IO_OUT; out_data<=AC.
  - 7 HALT -> HALT.
  - 8 SKIPCOND: IR[27:26] selects the test. 00 = AC<0 (signed); 01 = AC==0; 10 = AC>0 (signed); 11 = never. If the test is true, PC<=PC+1 (wrapping). Then FETCH.
  - 9 JUMP: PC<=X, then FETCH.
  - A CLEAR: AC<=0, then FETCH.
  - 0, B-F: illegal<=1, then HALT.
- LOAD/ADD/SUBT operand path: OP_ADDR -> OP_RD (read strobe) -> OP_LAT (MBR<=mem_rdata) -> EXEC.
- EXEC:
  - LOAD: AC<=MBR.
  - ADD: alu_sel=ALU_ADD, AC<=alu_out.
  - SUBT: alu_sel=ALU_SUB, AC<=alu_out.
  - Then FETCH.
- STORE: ST_ADDR -> ST_WR (write strobe, mem_wdata=MBR) -> FETCH.
- IO_IN: in_ready=1. When in_valid is also 1, AC<=in_data and go to FETCH; otherwise stay.
- IO_OUT: out_valid=1 with out_data stable. When out_ready is also 1, go to FETCH; otherwise stay.
- HALT: halted=1, bus idle, terminal until reset. start is ignored.
- Arithmetic wraps modulo 2^DATA_WIDTH; no overflow flag.

## Timing
- Cycles from entering FETCH to the next FETCH:
  - CLEAR, JUMP, SKIPCOND: 4.
  - STORE: 6.
  - LOAD, ADD, SUBT: 8.
  - INPUT/OUTPUT: 5 + number of cycles waited for the handshake.
- HALT: halted rises 4 cycles after entering FETCH.
- start: sampled high in IDLE -> FETCH on the next cycle.
- Handshakes: a transfer occurs on an edge where valid and ready are both high. in_ready and out_valid are high only in their state. They drop the cycle after the transfer.
- RAM: write lands at the end of ST_WR. Read data is captured in the cycle after the read-strobe cycle.
- Reset mid-instruction, including ST_WR: strobes are forced low in the same cycle; IDLE on the next edge. No partial register update survives.
- PC=2^ADDR_WIDTH-1 fetch: PC wraps to 0.
- SKIPCOND at the wrap point also wraps.

## Test plan
- Reset with start=0 for 5 cycles -> pc=0x100, ac=0, halted=0, mem_cs=0 every cycle.
- Program at 0x100: 0x1000010A, 0x3000010B, 0x2000010C, 0x70000000, with M[0x10A]=5, M[0x10B]=7. Pulse start -> M[0x10C]=12, ac=12, halted=1 exactly 26 cycles after FETCH entry, pc=0x104.
- M[0x10A]=0xFFFFFFFF. Program LOAD 0x10A, SKIPCOND 0x80000000, HALT, CLEAR, HALT -> the first HALT is skipped, ac=0, halted with pc=0x105. Repeat with IR[27:26]=01 -> no skip, pc=0x103.
- Program INPUT, OUTPUT, HALT. Hold in_valid=0 for 3 cycles, then in_valid=1 with in_data=0x2A. Delay out_ready 2 cycles -> out_data=0x2A stable while out_valid=1. Single-cycle transfer on each side; ac=0x2A.
- Opcode 0xB0000000 at 0x100 -> illegal=1, halted=1, pc=0x101, no memory write.
- Assert reset during ST_WR of a STORE -> mem_we=0 in that cycle, target word unchanged, IDLE with pc=0x100 after release.
